// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable-threshold synchronous FIFO.
// Used by fifo_sync_prog and its storage sub-module.
package fifo_pkg;

    localparam int unsigned PTR_STEP = 1;
    localparam int unsigned STAT_LVL_W = 32;

    typedef struct packed {
        logic                  overflow;
        logic [STAT_LVL_W-1:0] high_water;
    } fifo_stats_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Explicit wrap so pointers stay in range when DEPTH is not a power of two.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - PTR_STEP) ? 0 : ptr + PTR_STEP;
    endfunction

endpackage

// File: rtl/fifo_sync_prog_mem.sv
// Storage array for fifo_sync_prog: one synchronous write port and one asynchronous read port.
// The array has no reset, so its contents survive a reset.
module fifo_sync_prog_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock first-word-fall-through FIFO with runtime almost-full and almost-empty thresholds and a synchronous flush.
// Defining FIFO_SYNC_PROG_STATS_EN adds the ports STAT_CLR, OVERFLOW and HIGH_WATER.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK_IN,
    input  logic             RESET_IN,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic [AW:0]      LEVEL,
    input  logic [AW:0]      AF_LEVEL,
    input  logic [AW:0]      AE_LEVEL,
    output logic             ALMOST_FULL,
`ifdef FIFO_SYNC_PROG_STATS_EN
    input  logic             STAT_CLR,
    output logic             OVERFLOW,
    output logic [AW:0]      HIGH_WATER,
`endif
    output logic             ALMOST_EMPTY
);

    localparam int LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_next;
    logic [AW-1:0] w_wptr_inc;
    logic [AW-1:0] w_rptr_inc;
    logic          w_push;
    logic          w_pop;

    // Ready and valid depend only on the stored level and FLUSH, so a full FIFO never passes data straight through.
    assign DIN_READY  = (r_level < DEPTH_LVL) && !FLUSH;
    assign DOUT_VALID = (r_level != '0) && !FLUSH;
    assign w_push     = DIN_VALID && DIN_READY;
    assign w_pop      = DOUT_VALID && DOUT_READY;
    assign w_wptr_inc = AW'(ptr_next(32'(r_wptr), DEPTH));
    assign w_rptr_inc = AW'(ptr_next(32'(r_rptr), DEPTH));

    always_comb begin
        w_level_next = r_level;
        if (FLUSH) begin
            w_level_next = '0;
        end else if (w_push && !w_pop) begin
            w_level_next = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - LW'(1);
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (FLUSH) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= w_wptr_inc;
                end
                if (w_pop) begin
                    r_rptr <= w_rptr_inc;
                end
            end
            r_level <= w_level_next;
        end
    end

    fifo_sync_prog_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (CLK_IN),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (DIN),
        .i_raddr (r_rptr),
        .o_rdata (DOUT)
    );

    assign LEVEL        = r_level;
    assign ALMOST_FULL  = r_level >= AF_LEVEL;
    assign ALMOST_EMPTY = r_level <= AE_LEVEL;

`ifdef FIFO_SYNC_PROG_STATS_EN
    fifo_stats_t r_stats;

    // STAT_CLR wins over a same-cycle set. FLUSH does not clear the statistics.
    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            r_stats <= '0;
        end else if (STAT_CLR) begin
            r_stats <= '0;
        end else begin
            if (DIN_VALID && !DIN_READY && !FLUSH) begin
                r_stats.overflow <= 1'b1;
            end
            if (STAT_LVL_W'(w_level_next) > r_stats.high_water) begin
                r_stats.high_water <= STAT_LVL_W'(w_level_next);
            end
        end
    end

    assign OVERFLOW   = r_stats.overflow;
    assign HIGH_WATER = LW'(r_stats.high_water);
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed scoreboard bench for fifo_sync_prog with DEPTH=5 and WIDTH=8.
// The statistics checks compile only when FIFO_SYNC_PROG_STATS_EN is defined.
module tb_fifo_sync_prog;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;

    logic       clk = 1'b0;
    logic       resetN;
    logic       flush;
    logic [7:0] din;
    logic       dinValid;
    logic       dinReady;
    logic [7:0] dout;
    logic       doutValid;
    logic       doutReady;
    logic [3:0] level;
    logic [3:0] afLevel;
    logic [3:0] aeLevel;
    logic       almostFull;
    logic       almostEmpty;
`ifdef FIFO_SYNC_PROG_STATS_EN
    logic       statClr;
    logic       overflow;
    logic [3:0] highWater;
    bit         mOverflow;
    int         mHigh;
`endif

    int         total = 0;
    int         bad = 0;
    int         mLevel = 0;
    logic [7:0] sb[$];

    fifo_sync_prog #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK_IN       (clk),
        .RESET_IN     (resetN),
        .FLUSH        (flush),
        .DIN          (din),
        .DIN_VALID    (dinValid),
        .DIN_READY    (dinReady),
        .DOUT         (dout),
        .DOUT_VALID   (doutValid),
        .DOUT_READY   (doutReady),
        .LEVEL        (level),
        .AF_LEVEL     (afLevel),
        .AE_LEVEL     (aeLevel),
        .ALMOST_FULL  (almostFull),
`ifdef FIFO_SYNC_PROG_STATS_EN
        .STAT_CLR     (statClr),
        .OVERFLOW     (overflow),
        .HIGH_WATER   (highWater),
`endif
        .ALMOST_EMPTY (almostEmpty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".level"}, 32'(level), mLevel);
        checkOutput({tag, ".dinReady"}, 32'(dinReady), 32'((mLevel < DEPTH) && !flush));
        checkOutput({tag, ".doutValid"}, 32'(doutValid), 32'((mLevel > 0) && !flush));
        checkOutput({tag, ".almostFull"}, 32'(almostFull), 32'(mLevel >= int'(afLevel)));
        checkOutput({tag, ".almostEmpty"}, 32'(almostEmpty), 32'(mLevel <= int'(aeLevel)));
`ifdef FIFO_SYNC_PROG_STATS_EN
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(mOverflow));
        checkOutput({tag, ".highWater"}, 32'(highWater), mHigh);
`endif
    endtask

    // Runs one clock with the inputs as they are now driven and predicts the handshakes from the bench's own level model.
    task automatic applyStimulus(input string tag);
        bit doPush;
        bit doPop;
        int newLevel;
        doPush = dinValid && (mLevel < DEPTH) && !flush;
        doPop  = doutReady && (mLevel > 0) && !flush;
        if (doPop) begin
            if (sb.size() == 0) begin
                checkOutput({tag, ".sbEmpty"}, 32'(sb.size()), 32'd1);
            end else begin
                checkOutput({tag, ".dout"}, 32'(dout), 32'(sb.pop_front()));
            end
        end
        if (doPush) sb.push_back(din);
        if (flush) sb.delete();
        newLevel = flush ? 0 : mLevel + int'(doPush) - int'(doPop);
`ifdef FIFO_SYNC_PROG_STATS_EN
        if (statClr) begin
            mOverflow = 1'b0;
            mHigh = 0;
        end else begin
            if (dinValid && (mLevel == DEPTH) && !flush) mOverflow = 1'b1;
            if (newLevel > mHigh) mHigh = newLevel;
        end
`endif
        mLevel = newLevel;
        @(posedge clk);
        #1;
        checkState(tag);
    endtask

    task automatic pushWord(input logic [7:0] w, input string tag);
        din = w;
        dinValid = 1'b1;
        doutReady = 1'b0;
        applyStimulus(tag);
        dinValid = 1'b0;
    endtask

    task automatic popWord(input string tag);
        dinValid = 1'b0;
        doutReady = 1'b1;
        applyStimulus(tag);
        doutReady = 1'b0;
    endtask

    initial begin
        resetN = 1'b0;
        flush = 1'b0;
        din = '0;
        dinValid = 1'b0;
        doutReady = 1'b0;
        afLevel = 4'd0;
        aeLevel = 4'd1;
`ifdef FIFO_SYNC_PROG_STATS_EN
        statClr = 1'b0;
        mOverflow = 1'b0;
        mHigh = 0;
`endif
        #1;
        checkState("resetAf0");
        afLevel = 4'd4;
        #1;
        checkState("reset");
        #1;
        resetN = 1'b1;
        $display("[TB] reset released");

        for (int i = 1; i <= 5; i++) pushWord(8'(i), "fill");
        din = 8'h06;
        dinValid = 1'b1;
        applyStimulus("fullHold");
        dinValid = 1'b0;
        for (int i = 0; i < 5; i++) popWord("drain");

        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 3; k++) pushWord(8'(8'h10 + g * 3 + k), "wrapPush");
            for (int k = 0; k < 3; k++) popWord("wrapPop");
        end

        pushWord(8'h20, "simPre");
        pushWord(8'h21, "simPre");
        din = 8'hAA;
        dinValid = 1'b1;
        doutReady = 1'b1;
        applyStimulus("simPushPop");
        for (int i = 0; i < 3; i++) pushWord(8'(8'h22 + i), "simFill");
        din = 8'hBB;
        dinValid = 1'b1;
        doutReady = 1'b1;
        applyStimulus("fullPushPop");
        dinValid = 1'b0;
        doutReady = 1'b0;
        for (int i = 0; i < 4; i++) popWord("simDrain");

        afLevel = 4'd4;
        aeLevel = 4'd1;
        for (int i = 0; i < 4; i++) pushWord(8'(8'h60 + i), "thresh");
        din = 8'h77;
        dinValid = 1'b1;
        flush = 1'b1;
        applyStimulus("flush");
        flush = 1'b0;
        dinValid = 1'b0;
        #1;
        checkState("postFlush");
        pushWord(8'h55, "afterFlush");
        popWord("afterFlushPop");

        for (int i = 0; i < 3; i++) pushWord(8'(8'h31 + i), "preReset");
        #3;
        resetN = 1'b0;
        mLevel = 0;
        sb.delete();
`ifdef FIFO_SYNC_PROG_STATS_EN
        mOverflow = 1'b0;
        mHigh = 0;
`endif
        #1;
        checkState("asyncReset");
        #1;
        resetN = 1'b1;
        popWord("resetNoData");
        pushWord(8'h40, "postReset");
        popWord("postResetPop");

`ifdef FIFO_SYNC_PROG_STATS_EN
        for (int i = 0; i < 5; i++) pushWord(8'(8'h80 + i), "statFill");
        din = 8'h99;
        dinValid = 1'b1;
        applyStimulus("statStall");
        applyStimulus("statStall");
        dinValid = 1'b0;
        flush = 1'b1;
        applyStimulus("statFlush");
        flush = 1'b0;
        statClr = 1'b1;
        applyStimulus("statClr");
        statClr = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
